// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fulladder stepped LSB first over WIDTH cycles.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag (ovf).

module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic S
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic             fa_s, fa_cout;

    fulladder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .Cout (fa_cout),
        .S    (fa_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // S/Cout only change on the completion edge, so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                S    <= {fa_s, sum_sh[WIDTH-1:1]};
                Cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB on the final step
                ovf  <= carry ^ fa_cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl against an arithmetic model.
// Define SERIAL_ADDER_OVF_EN to also check the ovf output.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             busy, done, Cout;
    logic [WIDTH-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    task automatic checkResult(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
        int unsigned total;
        int          sa, sb, ss;
        total = int'(a) + int'(b) + int'(cin);
        checkOutput({tag, "_S"}, 32'(S), total % (1 << WIDTH));
        checkOutput({tag, "_Cout"}, 32'(Cout), (total >> WIDTH) & 1);
        sa = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
        sb = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
        ss = sa + sb + int'(cin);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, "_ovf"}, 32'(ovf),
                    (ss > (1 << (WIDTH-1)) - 1 || ss < -(1 << (WIDTH-1))) ? 1 : 0);
`else
        if (ss == 12345) $display("[TB] note: unreachable signed sum");
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
        int               lat;
        logic [WIDTH-1:0] hold_s;
        hold_s = S;
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = cin;
        @(posedge clk); #1;
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
        checkOutput({tag, "_busy"}, 32'(busy), 1);
        lat = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            checkOutput({tag, "_hold"}, 32'(S), 32'(hold_s));
        end
        checkOutput({tag, "_lat"}, lat, WIDTH);
        checkResult(tag, a, b, cin);
        checkOutput({tag, "_busy_end"}, 32'(busy), 0);
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        int first, second, ndone;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;

        // start during reset must be ignored
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_S", 32'(S), 0);
        checkOutput("rst_Cout", 32'(Cout), 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        applyStimulus("zero", 8'h00, 8'h00, 1'b0);
        applyStimulus("ff01", 8'hFF, 8'h01, 1'b0);
        applyStimulus("a55a", 8'hA5, 8'h5A, 1'b1);
        applyStimulus("3c42", 8'h3C, 8'h42, 1'b0);
        applyStimulus("7f01", 8'h7F, 8'h01, 1'b0);
        applyStimulus("ff01b", 8'hFF, 8'h01, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 2 * WIDTH + 4; i++) begin
            @(posedge clk); #1;
            start = (i == 3);
            if (i == 3) begin A = 8'hFF; B = 8'hFF; Cin = 1'b1; end
            if (done) begin
                ndone++;
                checkResult("ign", 8'h10, 8'h20, 1'b0);
            end
        end
        start = 1'b0;
        checkOutput("ign_ndone", ndone, 1);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0;
        first = -1; second = -1;
        for (int i = 1; i <= 3 * WIDTH; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin A = 8'h80; B = 8'h80; end
            if (done) begin
                if (first < 0) begin
                    first = i;
                    checkResult("b2b0", 8'h01, 8'h01, 1'b0);
                end else begin
                    second = i;
                    checkResult("b2b1", 8'h80, 8'h80, 1'b0);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b_lat", first, WIDTH + 1);
        checkOutput("b2b_gap", second - first, WIDTH + 1);
        @(posedge clk); #1;
        checkOutput("b2b_idle", 32'(busy), 0);

        // reset in the middle of a run
        @(negedge clk);
        start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 0);
        checkOutput("mid_done", 32'(done), 0);
        checkOutput("mid_S", 32'(S), 0);
        checkOutput("mid_Cout", 32'(Cout), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checkOutput("mid_nodone", ndone, 0);
        applyStimulus("post", 8'h02, 8'h03, 1'b0);

        // randomised operands with random idle gaps
        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            applyStimulus("rnd", ra, rb, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
